// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared 32-word memory.
// Each grant runs IDLE -> ACCESS -> RESP, so one access completes every three cycles.
module mem_arbiter #(
    parameter logic [24:0] BASE_ADDRESS = 25'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;     // port served most recently
    logic        id_q, id_d;
    logic        we_q, we_d;
    logic        legal_q, legal_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d, mem_data_in_q, mem_data_in_d;

    logic        gnt_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_legal_s;
    logic [31:0] rd_value_s;

    // Winner selection: a lone requester always wins, contention goes to the port not served last.
    always_comb begin
        gnt_s       = (req0 && req1) ? ~last_q : req1;
        sel_we_s    = gnt_s ? we1 : we0;
        sel_addr_s  = gnt_s ? addr1 : addr0;
        sel_wdata_s = gnt_s ? wdata1 : wdata0;
        sel_legal_s = (sel_addr_s[1:0] == 2'b00) && (sel_addr_s[31:7] == BASE_ADDRESS);
        rd_value_s  = (legal_q && !we_q) ? mem_data_out : 32'd0;
    end

    // Next-state and registered-output logic; outputs default to zero every cycle.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        we_d          = we_q;
        legal_d       = legal_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err0_d        = 1'b0;
        err1_d        = 1'b0;
        rdata0_d      = 32'd0;
        rdata1_d      = 32'd0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = 32'd0;
        mem_data_in_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    id_d          = gnt_s;
                    we_d          = sel_we_s;
                    legal_d       = sel_legal_s;
                    mem_address_d = sel_addr_s;
                    mem_data_in_d = sel_wdata_s;
                    mem_write_d   = sel_legal_s && sel_we_s;
                    mem_read_d    = sel_legal_s && !sel_we_s;
                    state_d       = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (id_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = ~legal_q;
                    rdata1_d = rd_value_s;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = ~legal_q;
                    rdata0_d = rd_value_s;
                end
                state_d = RESP;
            end
            RESP: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset favours port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            id_q          <= 1'b0;
            we_q          <= 1'b0;
            legal_q       <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err0_q        <= 1'b0;
            err1_q        <= 1'b0;
            rdata0_q      <= 32'd0;
            rdata1_q      <= 32'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_data_in_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            id_q          <= id_d;
            we_q          <= we_d;
            legal_q       <= legal_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err0_q        <= err0_d;
            err1_q        <= err1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign err0        = err0_q;
    assign err1        = err1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected accesses and acks,
// an independent negedge monitor compares them against what the arbiter presents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, addr1 = 32'd0, wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1, err0, err1, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_address, mem_data_in, mem_data_out;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } ack_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    ack_t ack_q[$];
    acc_t acc_q[$];

    logic [31:0] mem [0:31];
    int          cyc = 0;
    logic        rst_smp;
    logic        done = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.BASE_ADDRESS(25'd0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Behavioural memory: no reset, combinational read, write on the strobe.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[6:2]] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_address[6:2]];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= reset;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares every strobe, ack and post-reset output against the scoreboard.
    always @(negedge clk) begin
        acc_t a;
        ack_t e;
        if (rst_smp === 1'b1) begin
            check("reset_outputs",
                  {31'd0, ack0 | ack1 | err0 | err1 | mem_read | mem_write |
                   (|rdata0) | (|rdata1) | (|mem_address) | (|mem_data_in)}, 32'd0);
        end
        if (mem_read || mem_write) begin
            if (acc_q.size() == 0) begin
                check("unexpected_strobe", {31'd0, mem_write}, {31'd0, ~mem_write});
            end else begin
                a = acc_q.pop_front();
                check("strobe_we", {31'd0, mem_write}, {31'd0, a.we});
                check("strobe_rd", {31'd0, mem_read}, {31'd0, ~a.we});
                check("mem_address", mem_address, a.addr);
                if (a.we) check("mem_data_in", mem_data_in, a.data);
            end
        end
        if (ack0 || ack1) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                e = ack_q.pop_front();
                check("ack_port", {30'd0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
                check("ack_cycle", 32'(cyc), 32'(e.cyc));
                check("rdata", e.port ? rdata1 : rdata0, e.rdata);
                check("err", {31'd0, e.port ? err1 : err0}, {31'd0, e.err});
                check("other_port_idle", (e.port ? rdata0 : rdata1) | {31'd0, e.port ? err0 : err1},
                      32'd0);
            end
        end
        if (done || cyc > 3000) begin
            check("timeout", {31'd0, done}, 32'd1);
            check("acks_outstanding", 32'(ack_q.size()), 32'd0);
            check("accesses_outstanding", 32'(acc_q.size()), 32'd0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input logic p, input logic [31:0] rd, input logic e, input int c);
        ack_t x;
        x.port = p; x.rdata = rd; x.err = e; x.cyc = c;
        ack_q.push_back(x);
    endtask

    task automatic push_acc(input logic w, input logic [31:0] a, input logic [31:0] d);
        acc_t x;
        x.we = w; x.addr = a; x.data = d;
        acc_q.push_back(x);
    endtask

    task automatic set_port(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
        end else begin
            we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
        end
    endtask

    task automatic single(input logic p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic strobe, input logic [31:0] exp_rd, input logic exp_err);
        int k;
        k = cyc;
        set_port(p, w, a, d);
        if (strobe) push_acc(w, a, d);
        push_ack(p, exp_rd, exp_err, k + 2);
        tick(2);
        req0 = 1'b0;
        req1 = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    // Stimulus: directed vectors with hand-computed responses.
    initial begin
        int k;
        tick(1);
        do_reset();

        single(1'b0, 1'b1, 32'h0C, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        single(1'b0, 1'b0, 32'h0C, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Simultaneous requests after reset: port 0 first, then port 1, then port 0 again.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            k = cyc;
            set_port(1'b0, 1'b0, r == 0 ? 32'h00 : 32'h08, 32'd0);
            set_port(1'b1, 1'b0, r == 0 ? 32'h04 : 32'h14, 32'd0);
            push_acc(1'b0, r == 0 ? 32'h00 : 32'h08, 32'd0);
            push_acc(1'b0, r == 0 ? 32'h04 : 32'h14, 32'd0);
            push_ack(1'b0, r == 0 ? 32'hA000_0000 : 32'hA000_0002, 1'b0, k + 2);
            push_ack(1'b1, r == 0 ? 32'hA000_0001 : 32'hA000_0005, 1'b0, k + 5);
            tick(2);
            req0 = 1'b0;
            tick(3);
            req1 = 1'b0;
            tick(1);
        end

        single(1'b1, 1'b0, 32'h06, 32'd0, 1'b0, 32'd0, 1'b1);
        single(1'b1, 1'b0, 32'h80, 32'd0, 1'b0, 32'd0, 1'b1);

        // Both ports held: grants alternate 0,1,0,1 every three cycles.
        k = cyc;
        set_port(1'b0, 1'b0, 32'h18, 32'd0);
        set_port(1'b1, 1'b0, 32'h1C, 32'd0);
        for (int i = 0; i < 4; i++) begin
            push_acc(1'b0, i[0] ? 32'h1C : 32'h18, 32'd0);
            push_ack(i[0], i[0] ? 32'hA000_0007 : 32'hA000_0006, 1'b0, k + 2 + 3 * i);
        end
        tick(11);
        req0 = 1'b0;
        req1 = 1'b0;
        tick(1);

        // req0 withdrawn during ACCESS still gets its ack.
        k = cyc;
        set_port(1'b0, 1'b0, 32'h20, 32'd0);
        push_acc(1'b0, 32'h20, 32'd0);
        push_ack(1'b0, 32'hA000_0008, 1'b0, k + 2);
        tick(1);
        req0 = 1'b0;
        tick(2);

        // Reset in the ACCESS cycle of a write: write lands, no ack.
        set_port(1'b0, 1'b1, 32'h10, 32'h12345678);
        push_acc(1'b1, 32'h10, 32'h12345678);
        tick(1);
        req0 = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        single(1'b0, 1'b0, 32'h10, 32'd0, 1'b1, 32'h12345678, 1'b0);

        tick(3);
        done = 1'b1;
    end

endmodule
